// File: rtl/instr_stream_encoder.sv
// Streaming RV32I field-to-word encoder that loads packed instructions into
// consecutive instruction-memory words behind a valid/ready handshake.
module instr_stream_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0]       word;
    logic              legal;
    logic              accept;

    // B and J immediates are byte offsets, so an odd offset cannot be encoded.
    always_comb begin
        word = '0;
        case (in_fmt)
            3'd0: word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            3'd2: word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            3'd3: word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_opcode};
            3'd4: word = {in_imm[31:12], in_rd, in_opcode};
            3'd5: word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                          in_rd, in_opcode};
            default: word = '0;
        endcase
        legal = (in_fmt <= 3'd5) && (in_opcode[1:0] == 2'b11)
                && !(((in_fmt == 3'd3) || (in_fmt == 3'd5)) && in_imm[0]);
    end

    assign in_ready = (state_q == LOAD) && !start && !stop;
    assign accept   = in_valid && in_ready;

    // start wins over stop and over any beat presented alongside it.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (start) begin
            state_d = LOAD;
            addr_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
        end else if (stop && (state_q == LOAD)) begin
            state_d = DONE;
        end else if (accept) begin
            if (legal) begin
                we_d    = 1'b1;
                waddr_d = addr_q;
                wdata_d = word;
                count_d = count_q + CNT_ONE;
                if (addr_q == '1) begin
                    state_d = DONE;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign err        = err_q;
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Randomized scoreboard bench for instr_stream_encoder: a field-level reference
// model predicts every write, and a negedge monitor checks what the DUT emits.
module tb_instr_stream_encoder;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } beat_t;

    typedef struct {
        int unsigned addr;
        logic [31:0] word;
        int unsigned cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, stop, in_valid, in_ready;
    logic [2:0]    in_fmt, in_funct3;
    logic [6:0]    in_opcode, in_funct7;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [31:0]   in_imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          err, done;

    int   nCompared   = 0;
    int   nMismatched = 0;
    exp_t expQ[$];
    int   mState = M_IDLE;
    int   mAddr  = 0;
    int   mCount = 0;
    bit   mErr   = 1'b0;

    instr_stream_encoder #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fmt     (in_fmt),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .err        (err),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Field placement written as shifts and masks on the instruction-set layout.
    function automatic logic [31:0] refEncode(input beat_t b);
        int unsigned w, imm;
        imm = b.imm;
        w = 32'(b.op) | (32'(b.f3) << 12) | (32'(b.rs1) << 15);
        case (b.fmt)
            3'd0: w = w | (32'(b.rd) << 7) | (32'(b.rs2) << 20) | (32'(b.f7) << 25);
            3'd1: w = w | (32'(b.rd) << 7) | ((imm & 32'hFFF) << 20);
            3'd2: w = w | ((imm & 31) << 7) | (32'(b.rs2) << 20) | (((imm >> 5) & 127) << 25);
            3'd3: w = w | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8)
                      | (32'(b.rs2) << 20) | (((imm >> 5) & 63) << 25) | (((imm >> 12) & 1) << 31);
            3'd4: w = 32'(b.op) | (32'(b.rd) << 7) | (imm & 32'hFFFFF000);
            default: w = 32'(b.op) | (32'(b.rd) << 7) | (((imm >> 12) & 255) << 12)
                      | (((imm >> 11) & 1) << 20) | (((imm >> 1) & 1023) << 21)
                      | (((imm >> 20) & 1) << 31);
        endcase
        return w;
    endfunction

    function automatic bit refLegal(input beat_t b);
        if (b.fmt >= 6) return 1'b0;
        if (b.op[1:0] != 2'b11) return 1'b0;
        if ((b.fmt == 3 || b.fmt == 5) && b.imm[0]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic beat_t mkBeat(input int fmt, input int op, input int rd, input int rs1,
                                     input int rs2, input int f3, input int f7, input int imm);
        beat_t b;
        b.fmt = 3'(fmt); b.op = 7'(op); b.rd = 5'(rd); b.rs1 = 5'(rs1);
        b.rs2 = 5'(rs2); b.f3 = 3'(f3); b.f7 = 7'(f7); b.imm = 32'(imm);
        return b;
    endfunction

    function automatic beat_t randBeat(input bit forceLegal);
        beat_t b;
        b = beat_t'({$urandom, $urandom, $urandom});
        b.fmt = 3'($urandom_range(0, 5));
        if (!forceLegal && ($urandom % 8 == 0)) b.fmt = 3'($urandom_range(6, 7));
        if (forceLegal || ($urandom % 8 != 0)) b.op[1:0] = 2'b11;
        if (forceLegal) b.imm[0] = 1'b0;
        return b;
    endfunction

    task automatic driveInputs(input logic s, input logic p, input logic v, input beat_t b);
        start = s; stop = p; in_valid = v;
        in_fmt = b.fmt; in_opcode = b.op; in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2;
        in_funct3 = b.f3; in_funct7 = b.f7; in_imm = b.imm;
    endtask

    // One clock of stimulus; entered and left just after a falling edge.
    task automatic applyStimulus(input logic s, input logic p, input logic v, input beat_t b,
                                 input bit useConst, input logic [31:0] constWord);
        bit expReady;
        exp_t e;
        driveInputs(s, p, v, b);
        expReady = (mState == M_LOAD) && !s && !p;
        #1 checkOutput("in_ready", in_ready, expReady);
        @(posedge clk);
        if (s) begin
            mState = M_LOAD; mAddr = 0; mCount = 0; mErr = 1'b0;
        end else if (p && mState == M_LOAD) begin
            mState = M_DONE;
        end else if (expReady && v) begin
            if (refLegal(b)) begin
                e.addr = mAddr;
                e.word = useConst ? constWord : refEncode(b);
                e.cnt  = mCount + 1;
                expQ.push_back(e);
                mCount++;
                if (mAddr == DEPTH - 1) mState = M_DONE;
                else mAddr++;
            end else begin
                mErr = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 32'h0);
    endtask

    task automatic checkResetValues();
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_imem_we", imem_we, 0);
        checkOutput("rst_imem_addr", imem_addr, 0);
        checkOutput("rst_imem_wdata", imem_wdata, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_done", done, 0);
    endtask

    // A beat accepted just before reset must never reach the memory.
    task automatic resetMidWrite(input beat_t b);
        driveInputs(1'b0, 1'b0, 1'b1, b);
        @(posedge clk);
        #1 rst_n = 1'b0;
        expQ.delete();
        mState = M_IDLE; mAddr = 0; mCount = 0; mErr = 1'b0;
        driveInputs(1'b0, 1'b0, 1'b0, '0);
        #1 checkResetValues();
        @(negedge clk);
        rst_n = 1'b1;
        idleCycle();
        checkOutput("idle_after_reset", in_ready, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (imem_we === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write", imem_we, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("imem_addr", imem_addr, e.addr);
                checkOutput("imem_wdata", imem_wdata, e.word);
                checkOutput("count_at_write", count, e.cnt);
            end
        end else if (imem_we !== 1'b0) begin
            checkOutput("imem_we", imem_we, 0);
        end
        checkOutput("count", count, mCount);
        checkOutput("err", err, mErr);
        checkOutput("done", done, mState == M_DONE);
    end

    initial begin
        rst_n = 1'b0;
        driveInputs(1'b0, 1'b0, 1'b0, '0);
        repeat (2) @(negedge clk);
        checkResetValues();
        rst_n = 1'b1;
        idleCycle();

        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, mkBeat(1, 7'b0010011, 1, 0, 0, 0, 0, 5), 1'b1, 32'h00500093);
        applyStimulus(1'b0, 1'b0, 1'b1, mkBeat(0, 7'b0110011, 3, 1, 2, 0, 0, 0), 1'b1, 32'h002081B3);
        applyStimulus(1'b0, 1'b0, 1'b1, mkBeat(2, 7'b0100011, 0, 1, 2, 2, 0, 8), 1'b1, 32'h0020A423);
        applyStimulus(1'b0, 1'b0, 1'b1, mkBeat(3, 7'b1100011, 0, 0, 0, 0, 0, 8), 1'b1, 32'h00000463);
        applyStimulus(1'b0, 1'b0, 1'b1, mkBeat(5, 7'b1101111, 1, 0, 0, 0, 0, 16), 1'b1, 32'h010000EF);
        idleCycle();

        applyStimulus(1'b0, 1'b0, 1'b1, mkBeat(6, 7'b0010011, 1, 0, 0, 0, 0, 5), 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, mkBeat(3, 7'b1100011, 0, 0, 0, 0, 0, 3), 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, mkBeat(1, 7'b0010011, 1, 0, 0, 0, 0, 5), 1'b1, 32'h00500093);

        applyStimulus(1'b0, 1'b1, 1'b1, randBeat(1'b1), 1'b0, 32'h0);
        idleCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, randBeat(1'b1), 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, mkBeat(1, 7'b0010011, 1, 0, 0, 0, 0, 5), 1'b1, 32'h00500093);

        for (int i = 0; i < DEPTH + 4; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, randBeat(1'b1), 1'b0, 32'h0);
        idleCycle();

        for (int i = 0; i < 600; i++)
            applyStimulus(1'($urandom % 40 == 0), 1'($urandom % 60 == 0),
                          1'($urandom % 4 != 0), randBeat(1'b0), 1'b0, 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, randBeat(1'b1), 1'b0, 32'h0);
        resetMidWrite(randBeat(1'b1));

        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, randBeat(1'b1), 1'b0, 32'h0);
        repeat (3) idleCycle();
        checkOutput("writes_outstanding", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/instr_stream_encoder.md
# instr_stream_encoder

Streaming RV32I instruction encoder and instruction-memory loader: the inverse of the control/format decode path. It accepts decoded instruction fields (format, opcode, registers, funct, immediate) over a valid/ready handshake and packs them into 32-bit RV32I words. It writes the words to consecutive instruction-memory addresses. It sits between the testbench/boot stimulus and the instruction memory, so programs can be built from fields rather than hand-assembled hex.

## Interface
- ADDR_W, 8: instruction-memory word-address width; capacity 2^ADDR_W words.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse: clear address/count/err, enter LOAD.
- stop  input  1  pulse: end loading, enter DONE.
- in_valid  input  1  field beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6–7 illegal.
- in_opcode  input  7  opcode field.
- in_rd, in_rs1, in_rs2  input  5 each  register fields.
- in_funct3  input  3; in_funct7  input  7.
- in_imm  input  32  immediate, byte offset for B/J.
- imem_we  output  1  write strobe.
- imem_addr  output  ADDR_W  word address.
- imem_wdata  output  32  encoded instruction.
- count  output  ADDR_W+1  words written since start.
- err  output  1  sticky, a beat was rejected.
- done  output  1  high in DONE.

## Operation
- FSM states are IDLE, LOAD and DONE. Reset enters IDLE.
- IDLE -> LOAD on start.
- LOAD -> DONE on stop, or after writing address 2^ADDR_W−1.
- DONE -> LOAD on start.
- start in any state restarts loading:
  - next address = 0; count = 0; err = 0.
  - A beat presented in the same cycle is not accepted.
  - start has priority over stop.
- in_ready = (state==LOAD) && !start && !stop.
- Encoding ({} = concatenation, MSB first):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Unused fields are ignored. Immediate bits above those listed are ignored; no range check.
- A beat is rejected if any of the following holds:
  - in_fmt ≥ 6;
  - opcode[1:0] ≠ 2'b11;
  - in_fmt is B or J and imm[0] ≠ 0.
- A rejected beat is still handshaken (consumed): no write, address does not advance, err sets.
- A legal accepted beat writes to the current address, then address += 1 and count += 1.
- Writing the last address (2^ADDR_W−1) forces DONE; the address does not wrap.

## Timing
- Reset values:
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, err=0, done=0, state IDLE.
- Write latency is 1 cycle: a beat accepted at edge N drives imem_we/addr/wdata during cycle N+1, registered.
- imem_we is a single-cycle pulse per legal beat.
- Full throughput: one beat per cycle while in LOAD.
- count and err update on the same edge as the imem_we assertion.
- Last address:
  - The final word is written in cycle N+1.
  - State is DONE and in_ready=0 from cycle N+1.
  - count = 2^ADDR_W.
- stop with in_valid in the same cycle: no beat is accepted, DONE next cycle. A write already pending from the previous cycle still completes.
- Reset mid-write aborts the pending write; outputs return to reset values asynchronously.

## Test plan
- start, then I beat (op 0010011, rd 1, rs1 0, f3 0, imm 5) -> cycle after accept: imem_we=1, addr 0, wdata 0x00500093, count 1.
- Back-to-back beats, one per cycle:
  - R beat (op 0110011, rd 3, rs1 1, rs2 2, f3 0, f7 0) -> 0x002081B3 @1.
  - S beat (op 0100011, rs1 1, rs2 2, f3 2, imm 8) -> 0x0020A423 @2.
  - B beat (op 1100011, rs1 0, rs2 0, f3 0, imm 8) -> 0x00000463 @3.
  - J beat (op 1101111, rd 1, imm 16) -> 0x010000EF @4.
  - Required: 5 consecutive imem_we pulses, count 5.
- Illegal beats:
  - fmt 6 -> consumed, no write, err=1, address unchanged.
  - B beat with imm 3 -> consumed, no write, err stays 1.
  - A following legal beat writes to the unchanged address.
- ADDR_W=2: 4 legal beats -> writes @0..3, done=1 and in_ready=0 after the 4th, count 4. A 5th in_valid is never accepted.
- stop and in_valid asserted together mid-stream -> beat not accepted, done=1. start then clears count and err, and the next beat writes @0.
- rst_n low one cycle after accept, before the write cycle -> no imem_we pulse; all outputs at reset values; state IDLE.
